arbitro_rr: RTL and testbench

Round-robin arbiter and router between the four input FIFOs (`FIFO_mod`, 8 entries) and the four output FIFOs of the switch. It pops at most one word per cycle from the non-empty input FIFOs, in rotating priority. It routes each word to one output FIFO using the word's 2-bit destination field. It stops issuing pops while any output FIFO reports `pause`, and resumes only when every output FIFO reports `continua`.

---
 rtl/arbitro_rr_pkg.sv | 14 +
 rtl/arbitro_rr_rr_sel4.sv | 31 +++
 rtl/arbitro_rr.sv | 134 +++++++++++++
 tb/tb_arbitro_rr.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the round-robin input arbiter / output router.
// State encodings and the position of the destination field inside a word.
package arbitro_rr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    localparam int NUM_PORTS = 4;
    localparam int DEST_W    = 2;

endpackage

// File: rtl/arbitro_rr_rr_sel4.sv
// Rotating-priority search over four requests.
// The search starts at ptr and wraps around modulo 4.
module rr_sel4
    import arbitro_rr_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx
);

    logic       found;
    logic [1:0] idx;

    // The first requester at or after ptr wins; 2-bit index arithmetic wraps naturally.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter popping the input FIFOs and routing each word, one cycle
// later, to the output FIFO named by its destination field.
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int BUS_SIZE  = 6,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           empty_in,
    input  logic [3:0]           valid_in,
    input  logic [BUS_SIZE-1:0]  data_in0,
    input  logic [BUS_SIZE-1:0]  data_in1,
    input  logic [BUS_SIZE-1:0]  data_in2,
    input  logic [BUS_SIZE-1:0]  data_in3,
    input  logic [3:0]           pause_out,
    input  logic [3:0]           continua_out,
    output logic [3:0]           pop,
    output logic [3:0]           push,
    output logic [BUS_SIZE-1:0]  data_out,
    output logic                 valid_out,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] fwd_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    state_t              cur_state, nxt_state;
    logic [1:0]          gnt_ptr;
    logic [1:0]          sel_d;
    logic                pop_d;
    logic [3:0]          gnt;
    logic [1:0]          gnt_idx;
    logic                stall_now;
    logic                resume;
    logic                all_empty;
    logic [BUS_SIZE-1:0] word;
    logic                word_valid;
    logic [DEST_W-1:0]   dest;

    assign stall_now = |pause_out;
    assign resume    = (&continua_out) & ~stall_now;
    assign all_empty = &empty_in;
    assign state     = cur_state;

    rr_sel4 u_sel (
        .req     (~empty_in),
        .ptr     (gnt_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // STALL never falls back to IDLE directly; it always resumes through ACTIVE.
    always_comb begin
        nxt_state = cur_state;
        pop       = '0;
        case (cur_state)
            IDLE: begin
                if (stall_now)       nxt_state = STALL;
                else if (!all_empty) nxt_state = ACTIVE;
            end
            ACTIVE: begin
                if (stall_now) begin
                    nxt_state = STALL;
                end else begin
                    pop = gnt;
                    if (all_empty) nxt_state = IDLE;
                end
            end
            STALL: begin
                if (resume) nxt_state = ACTIVE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_ptr <= '0;
            pop_d   <= 1'b0;
            sel_d   <= '0;
        end else begin
            pop_d <= |pop;
            if (|pop) begin
                gnt_ptr <= gnt_idx + 2'd1;
                sel_d   <= gnt_idx;
            end
        end
    end

    always_comb begin
        word       = data_in0;
        word_valid = valid_in[sel_d];
        case (sel_d)
            2'd0:    word = data_in0;
            2'd1:    word = data_in1;
            2'd2:    word = data_in2;
            default: word = data_in3;
        endcase
    end

    assign dest = word[BUS_SIZE-1 -: DEST_W];

    // A word popped last cycle is routed now regardless of any new pause.
    always_comb begin
        push      = '0;
        data_out  = '0;
        valid_out = 1'b0;
        if (pop_d && word_valid) begin
            push[dest] = 1'b1;
            data_out   = word;
            valid_out  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_cnt  <= '0;
            drop_cnt <= '0;
        end else if (pop_d) begin
            if (word_valid) fwd_cnt  <= fwd_cnt + 1'b1;
            else            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the arbiter.
module tb_arbitro_rr;

    logic       clk;
    logic       reset;
    logic [3:0] empty_in, valid_in, pause_out, continua_out;
    logic [5:0] dat [4];
    logic [3:0] pop, push;
    logic [5:0] data_out;
    logic       valid_out;
    logic [1:0] state;
    logic [7:0] fwd_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: abstract FSM number, pointer, one pending popped channel, counters.
    int m_state, m_ptr, m_ch, m_fwd, m_drop;
    bit m_pend;
    int exp_ch;
    logic [3:0]  exp_pop, exp_push;
    logic [5:0]  exp_data;
    logic        exp_valid;
    logic [32:0] exp_vec;
    wire  [32:0] got_vec = {pop, push, data_out, valid_out, state, fwd_cnt, drop_cnt};

    arbitro_rr #(.BUS_SIZE(6), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .empty_in     (empty_in),
        .valid_in     (valid_in),
        .data_in0     (dat[0]),
        .data_in1     (dat[1]),
        .data_in2     (dat[2]),
        .data_in3     (dat[3]),
        .pause_out    (pause_out),
        .continua_out (continua_out),
        .pop          (pop),
        .push         (push),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .state        (state),
        .fwd_cnt      (fwd_cnt),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_eval();
        logic [5:0] w;
        exp_pop = 4'b0; exp_ch = 0; exp_push = 4'b0; exp_data = 6'b0; exp_valid = 1'b0;
        if (m_state == 1 && pause_out == 4'b0) begin
            for (int k = 0; k < 4; k++) begin
                int ch;
                ch = (m_ptr + k) % 4;
                if (exp_pop == 4'b0 && !empty_in[ch]) begin
                    exp_pop = 4'(1 << ch);
                    exp_ch  = ch;
                end
            end
        end
        if (m_pend && valid_in[m_ch]) begin
            w = dat[m_ch];
            exp_push  = 4'(1 << w[5:4]);
            exp_data  = w;
            exp_valid = 1'b1;
        end
        exp_vec = {exp_pop, exp_push, exp_data, exp_valid, 2'(m_state), 8'(m_fwd), 8'(m_drop)};
    endtask

    task automatic model_tick();
        bit stall, res;
        if (reset) begin
            m_state = 0; m_ptr = 0; m_pend = 0; m_ch = 0; m_fwd = 0; m_drop = 0;
        end else begin
            if (m_pend) begin
                if (valid_in[m_ch]) m_fwd  = (m_fwd + 1) % 256;
                else                m_drop = (m_drop + 1) % 256;
            end
            m_pend = (exp_pop != 4'b0);
            if (m_pend) begin
                m_ch  = exp_ch;
                m_ptr = (exp_ch + 1) % 4;
            end
            stall = (pause_out != 4'b0);
            res   = (continua_out == 4'hF) && !stall;
            case (m_state)
                0: if (stall) m_state = 2; else if (empty_in != 4'hF) m_state = 1;
                1: if (stall) m_state = 2; else if (empty_in == 4'hF) m_state = 0;
                default: if (res) m_state = 1;
            endcase
        end
    endtask

    task automatic drive_idle_inputs();
        empty_in = 4'h0; valid_in = 4'hF; pause_out = 4'h0; continua_out = 4'hF;
        for (int i = 0; i < 4; i++) dat[i] = 6'($urandom);
    endtask

    task automatic apply_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset = 1'b1;
            drive_idle_inputs();
            #1;
            model_eval();
            model_tick();
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (got_vec !== 33'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%h exp=%h", c, got_vec, 33'b0);
            end
            model_eval();
            model_tick();
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset = 1'b0;
            #1;
            model_eval();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL reset_release cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
            end
            checks++;
            if (pop !== (c == 0 ? 4'b0000 : 4'b0001)) begin
                errors++;
                $display("[TB] FAIL reset_first_pop cyc=%0d got=%b exp=%b", c, pop, (c == 0 ? 4'b0000 : 4'b0001));
            end
            model_tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] rr_seq [5];
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            reset = 1'b0;
            drive_idle_inputs();
            #1;
            model_eval();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL rr_cycle cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
            end
            if (c >= 1 && c <= 5) begin
                checks++;
                if (pop !== rr_seq[c-1]) begin
                    errors++;
                    $display("[TB] FAIL rr_order cyc=%0d got=%b exp=%b", c, pop, rr_seq[c-1]);
                end
            end
            if (c == 7) begin
                checks++;
                if (fwd_cnt !== 8'd5) begin
                    errors++;
                    $display("[TB] FAIL rr_fwd_cnt got=%0d exp=5", fwd_cnt);
                end
            end
            model_tick();
        end
    endtask

    task automatic test_routing();
        apply_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            reset = 1'b0;
            drive_idle_inputs();
            empty_in = 4'b1011;
            dat[2]   = 6'b11_0101;
            if (c == 3) valid_in = 4'b1011;
            #1;
            model_eval();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL route_cycle cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
            end
            if (c == 2) begin
                checks++;
                if ({push, data_out, valid_out} !== {4'b1000, 6'h35, 1'b1}) begin
                    errors++;
                    $display("[TB] FAIL route_valid got=%b/%h/%b exp=1000/35/1", push, data_out, valid_out);
                end
            end
            if (c == 3) begin
                checks++;
                if ({push, data_out, valid_out} !== 11'b0) begin
                    errors++;
                    $display("[TB] FAIL route_invalid got=%b/%h/%b exp=0000/00/0", push, data_out, valid_out);
                end
            end
            if (c == 4) begin
                checks++;
                if (drop_cnt !== 8'd1) begin
                    errors++;
                    $display("[TB] FAIL route_drop_cnt got=%0d exp=1", drop_cnt);
                end
            end
            model_tick();
        end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            reset = 1'b0;
            drive_idle_inputs();
            case (c)
                4, 5:    pause_out = 4'b0010;
                6:       continua_out = 4'b0111;
                7:       pause_out = 4'b0010;
                default: ;
            endcase
            #1;
            model_eval();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL stall_cycle cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
            end
            if (c == 4) begin
                checks++;
                if ({pop, valid_out, state} !== {4'b0000, 1'b1, 2'd1}) begin
                    errors++;
                    $display("[TB] FAIL stall_inflight got=%b/%b/%0d exp=0000/1/1", pop, valid_out, state);
                end
            end
            if (c >= 5 && c <= 8) begin
                checks++;
                if ({pop, state} !== {4'b0000, 2'd2}) begin
                    errors++;
                    $display("[TB] FAIL stall_hold cyc=%0d got=%b/%0d exp=0000/2", c, pop, state);
                end
            end
            if (c == 9) begin
                checks++;
                if ({pop, state} !== {4'b1000, 2'd1}) begin
                    errors++;
                    $display("[TB] FAIL stall_resume got=%b/%0d exp=1000/1", pop, state);
                end
            end
            model_tick();
        end
    endtask

    task automatic test_sparse();
        logic [3:0] sp_empty [6];
        logic [3:0] sp_pop   [6];
        logic [1:0] sp_state [6];
        sp_empty = '{4'b0000, 4'b0000, 4'b0111, 4'b0110, 4'b1111, 4'b1111};
        sp_pop   = '{4'b0000, 4'b0001, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
        sp_state = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            reset = 1'b0;
            drive_idle_inputs();
            empty_in = sp_empty[c];
            #1;
            model_eval();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL sparse_cycle cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
            end
            checks++;
            if ({pop, state} !== {sp_pop[c], sp_state[c]}) begin
                errors++;
                $display("[TB] FAIL sparse_pop cyc=%0d got=%b/%0d exp=%b/%0d", c, pop, state, sp_pop[c], sp_state[c]);
            end
            model_tick();
        end
    endtask

    task automatic test_midstream_reset();
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            reset = (c == 3);
            drive_idle_inputs();
            #1;
            model_eval();
            if (c != 3) begin
                checks++;
                if (got_vec !== exp_vec) begin
                    errors++;
                    $display("[TB] FAIL midreset_cycle cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
                end
            end
            if (c == 4) begin
                checks++;
                if ({push, valid_out, state, fwd_cnt, drop_cnt} !== 23'b0) begin
                    errors++;
                    $display("[TB] FAIL midreset_clear got=%b/%b/%0d/%0d/%0d exp=0000/0/0/0/0",
                             push, valid_out, state, fwd_cnt, drop_cnt);
                end
            end
            model_tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            reset        = ($urandom_range(0, 99) == 0);
            empty_in     = 4'($urandom) | 4'($urandom);
            valid_in     = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            pause_out    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            continua_out = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            for (int i = 0; i < 4; i++) dat[i] = 6'($urandom);
            #1;
            model_eval();
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random_cycle cyc=%0d got=%h exp=%h", c, got_vec, exp_vec);
            end
            model_tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle_inputs();
        m_state = 0; m_ptr = 0; m_pend = 0; m_ch = 0; m_fwd = 0; m_drop = 0;
        test_reset();
        test_round_robin();
        test_routing();
        test_stall();
        test_sparse();
        test_midstream_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
